// File: rtl/launch_pad_if.sv
// rtl/launch_pad_if.sv - board pin bundle for launch_pad (keypad, DIP switches, piezo, LEDs)
interface launch_pad_if;
  logic BTN1, BTN2, BTN3, BTN4, BTN5, BTN6, BTN7, BTN8, BTN9;
  logic BTN_0, BTN_star, BTN_sharp;
  logic Dip_1, Dip_2, Dip_3, Dip_4, Dip_6, Dip_7, Dip_8;
  logic [3:0] Dout;
  logic Pout;
  logic led_1, led_2, led_3, led_4, led_5, led_6, led_7, led_8;
  logic led_1_R, led_1_G, led_1_B, led_2_R, led_2_G, led_2_B;
  logic led_3_R, led_3_G, led_3_B, led_4_R, led_4_G, led_4_B;

  modport master (
    output BTN1, BTN2, BTN3, BTN4, BTN5, BTN6, BTN7, BTN8, BTN9, BTN_0, BTN_star, BTN_sharp,
    output Dip_1, Dip_2, Dip_3, Dip_4, Dip_6, Dip_7, Dip_8,
    input  Dout, Pout, led_1, led_2, led_3, led_4, led_5, led_6, led_7, led_8,
    input  led_1_R, led_1_G, led_1_B, led_2_R, led_2_G, led_2_B,
    input  led_3_R, led_3_G, led_3_B, led_4_R, led_4_G, led_4_B
  );

  modport slave (
    input  BTN1, BTN2, BTN3, BTN4, BTN5, BTN6, BTN7, BTN8, BTN9, BTN_0, BTN_star, BTN_sharp,
    input  Dip_1, Dip_2, Dip_3, Dip_4, Dip_6, Dip_7, Dip_8,
    output Dout, Pout, led_1, led_2, led_3, led_4, led_5, led_6, led_7, led_8,
    output led_1_R, led_1_G, led_1_B, led_2_R, led_2_G, led_2_B,
    output led_3_R, led_3_G, led_3_B, led_4_R, led_4_G, led_4_B
  );
endinterface

// File: rtl/launch_pad.sv
// rtl/launch_pad.sv - 12-key launchpad controller: key select, latch, piezo tone, LED feedback
// Optional key debounce enabled by defining LAUNCHPAD_DEBOUNCE_EN.
module launch_pad #(
  parameter int PRESCALE        = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic         CLK,
  input logic         RST,
  launch_pad_if.slave pads
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [11:0] key_pins, keys;
  logic [2:0]  octave;
  logic [1:0]  colour;

  logic [11:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic        latch_vld_q, latch_vld_d, note_vld_q, note_vld_d;
  logic [3:0]  latch_idx_q, latch_idx_d, note_idx_q, note_idx_d;
  logic [2:0]  note_oct_q, note_oct_d;
  logic [10:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]  dout_q, dout_d;
  logic        pout_q, pout_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] rgb_q, rgb_d;

  logic        win_vld, act_vld, changed, tick;
  logic [3:0]  win_idx, act_idx;
  logic [10:0] half;
  logic [2:0]  rgb_bits;
  logic [1:0]  row;

  assign key_pins = {pads.BTN_sharp, pads.BTN_star, pads.BTN_0, pads.BTN9, pads.BTN8,
                     pads.BTN7, pads.BTN6, pads.BTN5, pads.BTN4, pads.BTN3, pads.BTN2, pads.BTN1};
  assign octave   = {pads.Dip_1, pads.Dip_2, pads.Dip_3};
  assign colour   = {pads.Dip_7, pads.Dip_8};

  function automatic logic [10:0] half_base(input logic [3:0] idx);
    case (idx)
      4'd0:    half_base = 11'd1911;
      4'd1:    half_base = 11'd1804;
      4'd2:    half_base = 11'd1703;
      4'd3:    half_base = 11'd1607;
      4'd4:    half_base = 11'd1517;
      4'd5:    half_base = 11'd1432;
      4'd6:    half_base = 11'd1351;
      4'd7:    half_base = 11'd1276;
      4'd8:    half_base = 11'd1204;
      4'd9:    half_base = 11'd1136;
      4'd10:   half_base = 11'd1073;
      default: half_base = 11'd1012;
    endcase
  endfunction

`ifdef LAUNCHPAD_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [11:0]         db_lvl_q, db_lvl_d;
  logic [11:0][DW-1:0] db_cnt_q, db_cnt_d;

  // A key's level flips only once it has disagreed for DEBOUNCE_CYCLES samples in a row.
  always_comb begin
    db_lvl_d = db_lvl_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 12; i++) begin
      if (sync2_q[i] == db_lvl_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_lvl_d[i] = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
    end
  end
  assign keys = db_lvl_q;
`else
  assign keys = sync2_q;
`endif

  always_comb begin
    sync1_d = key_pins;
    sync2_d = sync1_q;
    prev_d  = keys;

    // Scan downwards so the lowest pressed note index is the last one written.
    win_vld = 1'b0;
    win_idx = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (keys[i]) begin
        win_vld = 1'b1;
        win_idx = 4'(i);
      end
    end

    latch_vld_d = latch_vld_q;
    latch_idx_d = latch_idx_q;
    if (!pads.Dip_6) begin
      latch_vld_d = 1'b0;
      latch_idx_d = 4'd0;
    end else if (win_vld && !prev_q[win_idx]) begin
      if (latch_vld_q && latch_idx_q == win_idx) begin
        latch_vld_d = 1'b0;
      end else begin
        latch_vld_d = 1'b1;
        latch_idx_d = win_idx;
      end
    end

    act_vld = pads.Dip_6 ? latch_vld_d : win_vld;
    act_idx = pads.Dip_6 ? latch_idx_d : win_idx;

    if (!act_vld)            dout_d = 4'hF;
    else if (act_idx <= 4'd8) dout_d = act_idx + 4'd1;
    else if (act_idx == 4'd9) dout_d = 4'd0;
    else                     dout_d = act_idx;

    led_d = 8'd1 << octave;

    case (colour)
      2'b00:   rgb_bits = 3'b100;
      2'b01:   rgb_bits = 3'b010;
      2'b10:   rgb_bits = 3'b001;
      default: rgb_bits = 3'b111;
    endcase
    if (act_idx < 4'd3)      row = 2'd0;
    else if (act_idx < 4'd6) row = 2'd1;
    else if (act_idx < 4'd9) row = 2'd2;
    else                     row = 2'd3;
    rgb_d = '0;
    if (act_vld) begin
      case (row)
        2'd0:    rgb_d[2:0]  = rgb_bits;
        2'd1:    rgb_d[5:3]  = rgb_bits;
        2'd2:    rgb_d[8:6]  = rgb_bits;
        default: rgb_d[11:9] = rgb_bits;
      endcase
    end

    note_vld_d = act_vld;
    note_idx_d = act_idx;
    note_oct_d = octave;
    changed = (act_vld != note_vld_q) ||
              (act_vld && (act_idx != note_idx_q || octave != note_oct_q));

    half = half_base(act_idx) >> octave;
    if (half == 11'd0) half = 11'd1;
    tick = (pre_q == PW'(PRESCALE - 1));

    // Any note/octave change, silence or mute parks the tone generator at phase zero.
    if (changed || !act_vld || pads.Dip_4) begin
      cnt_d  = '0;
      pre_d  = '0;
      pout_d = 1'b0;
    end else begin
      pre_d  = tick ? '0 : pre_q + PW'(1);
      cnt_d  = cnt_q;
      pout_d = pout_q;
      if (tick) begin
        if (cnt_q == half - 11'd1) begin
          cnt_d  = '0;
          pout_d = ~pout_q;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      latch_vld_q <= 1'b0;
      latch_idx_q <= 4'd0;
      note_vld_q  <= 1'b0;
      note_idx_q  <= 4'd0;
      note_oct_q  <= 3'd0;
      cnt_q       <= '0;
      pre_q       <= '0;
      dout_q      <= 4'hF;
      pout_q      <= 1'b0;
      led_q       <= '0;
      rgb_q       <= '0;
`ifdef LAUNCHPAD_DEBOUNCE_EN
      db_lvl_q    <= '0;
      db_cnt_q    <= '0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      latch_vld_q <= latch_vld_d;
      latch_idx_q <= latch_idx_d;
      note_vld_q  <= note_vld_d;
      note_idx_q  <= note_idx_d;
      note_oct_q  <= note_oct_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      dout_q      <= dout_d;
      pout_q      <= pout_d;
      led_q       <= led_d;
      rgb_q       <= rgb_d;
`ifdef LAUNCHPAD_DEBOUNCE_EN
      db_lvl_q    <= db_lvl_d;
      db_cnt_q    <= db_cnt_d;
`endif
    end
  end

  assign pads.Dout = dout_q;
  assign pads.Pout = pout_q;
  assign {pads.led_8, pads.led_7, pads.led_6, pads.led_5,
          pads.led_4, pads.led_3, pads.led_2, pads.led_1} = led_q;
  assign {pads.led_4_R, pads.led_4_G, pads.led_4_B, pads.led_3_R, pads.led_3_G, pads.led_3_B,
          pads.led_2_R, pads.led_2_G, pads.led_2_B, pads.led_1_R, pads.led_1_G, pads.led_1_B} = rgb_q;
endmodule

// File: tb/tb_launch_pad.sv
// tb/tb_launch_pad.sv - randomized bench for launch_pad against a behavioural board model
module tb_launch_pad;
  localparam int PRESCALE = 1;
  localparam int DB       = 4;
`ifdef LAUNCHPAD_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  launch_pad_if pads();

  logic [11:0] keys_in;
  logic [2:0]  oct_in;
  logic        mute_in, latch_in, mon_en;
  logic [1:0]  col_in;

  assign {pads.BTN_sharp, pads.BTN_star, pads.BTN_0, pads.BTN9, pads.BTN8, pads.BTN7,
          pads.BTN6, pads.BTN5, pads.BTN4, pads.BTN3, pads.BTN2, pads.BTN1} = keys_in;
  assign {pads.Dip_1, pads.Dip_2, pads.Dip_3} = oct_in;
  assign pads.Dip_4 = mute_in;
  assign pads.Dip_6 = latch_in;
  assign {pads.Dip_7, pads.Dip_8} = col_in;

  launch_pad #(.PRESCALE(PRESCALE), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .pads (pads)
  );

  logic [7:0]  led_obs;
  logic [11:0] rgb_obs;
  assign led_obs = {pads.led_8, pads.led_7, pads.led_6, pads.led_5,
                    pads.led_4, pads.led_3, pads.led_2, pads.led_1};
  assign rgb_obs = {pads.led_4_R, pads.led_4_G, pads.led_4_B, pads.led_3_R, pads.led_3_G, pads.led_3_B,
                    pads.led_2_R, pads.led_2_G, pads.led_2_B, pads.led_1_R, pads.led_1_G, pads.led_1_B};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Board model: keys seen two edges late, notes by lowest index, tone phase from elapsed cycles.
  int          half_tbl[12] = '{1911, 1804, 1703, 1607, 1517, 1432, 1351, 1276, 1204, 1136, 1073, 1012};
  logic [11:0] m_s1, m_s2, m_prev, m_lvl;
  int          m_run[12];
  int          m_latch, m_key, m_start;
  int          m_cyc = 0;
  logic [3:0]  exp_dout;
  logic        exp_pout;
  logic [7:0]  exp_led;
  logic [11:0] exp_rgb;

  always @(posedge CLK) begin
    logic [11:0] cur;
    logic [2:0]  bits;
    int w, act, oct, half, key;
    m_cyc++;
    if (!RST) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_lvl = '0;
      for (int i = 0; i < 12; i++) m_run[i] = 0;
      m_latch = -1; m_key = -1; m_start = m_cyc;
      exp_dout = 4'hF; exp_pout = 1'b0; exp_led = '0; exp_rgb = '0;
    end else begin
`ifdef LAUNCHPAD_DEBOUNCE_EN
      cur = m_lvl;
      for (int i = 0; i < 12; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] >= DB) begin
            m_lvl[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
`else
      cur = m_s2;
`endif
      m_s2 = m_s1;
      m_s1 = keys_in;
      w = -1;
      for (int i = 11; i >= 0; i--) if (cur[i]) w = i;
      if (!latch_in) m_latch = -1;
      else if (w >= 0 && !m_prev[w]) m_latch = (m_latch == w) ? -1 : w;
      m_prev = cur;
      act = latch_in ? m_latch : w;
      oct = int'(oct_in);
      exp_led = 8'(1 << oct);
      if (act < 0)       exp_dout = 4'hF;
      else if (act <= 8) exp_dout = 4'(act + 1);
      else if (act == 9) exp_dout = 4'd0;
      else               exp_dout = 4'(act);
      case (col_in)
        2'b00:   bits = 3'b100;
        2'b01:   bits = 3'b010;
        2'b10:   bits = 3'b001;
        default: bits = 3'b111;
      endcase
      exp_rgb = '0;
      if (act >= 0) exp_rgb = 12'(bits) << (3 * (act / 3));
      key = (act < 0) ? -1 : act * 8 + oct;
      if (key != m_key) begin
        m_key = key;
        m_start = m_cyc;
      end
      if (act < 0 || mute_in) begin
        m_start = m_cyc;
        exp_pout = 1'b0;
      end else begin
        half = half_tbl[act] >> oct;
        if (half < 1) half = 1;
        exp_pout = (((m_cyc - m_start) / (half * PRESCALE)) % 2) != 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      check("dout", 32'(pads.Dout), 32'(exp_dout));
      check("pout", 32'(pads.Pout), 32'(exp_pout));
      check("led",  32'(led_obs),   32'(exp_led));
      check("rgb",  32'(rgb_obs),   32'(exp_rgb));
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic measure_half(input string tag, input int exp);
    int t, first, second;
    logic last;
    t = 0; first = -1; second = -1;
    @(negedge CLK);
    last = pads.Pout;
    while (second < 0 && t < 4000) begin
      @(negedge CLK);
      t++;
      if (pads.Pout !== last) begin
        last = pads.Pout;
        if (first < 0) first = t;
        else second = t;
      end
    end
    check(tag, (second < 0) ? 32'd0 : 32'(second - first), 32'(exp));
  endtask

  initial begin
    int seen;
    keys_in = 12'h001; oct_in = 3'd0; mute_in = 1'b0; latch_in = 1'b0; col_in = 2'b00;
    mon_en = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    mon_en = 1'b1;
    check("rst_dout", 32'(pads.Dout), 32'hF);
    check("rst_leds", 32'({led_obs, rgb_obs, pads.Pout}), 32'd0);
    RST = 1'b1;
    wait_cycles(LAT - 1);
    check("rel_dout_early", 32'(pads.Dout), 32'hF);
    wait_cycles(1);
    check("rel_dout", 32'(pads.Dout), 32'd1);

    oct_in = 3'd7;
    wait_cycles(LAT + 3);
    check("led_8", 32'(pads.led_8), 32'd1);
    check("led_1_R", 32'(pads.led_1_R), 32'd1);
    measure_half("half_oct7_btn1", 14);
    keys_in = '0;
    wait_cycles(LAT + 1);
    check("release_dout", 32'(pads.Dout), 32'hF);
    check("release_pout", 32'(pads.Pout), 32'd0);

    keys_in = 12'h804; col_in = 2'b01; oct_in = 3'd1;
    wait_cycles(LAT + 2);
    check("prio_dout", 32'(pads.Dout), 32'd3);
    check("prio_rgb", 32'(rgb_obs), 32'h002);
    measure_half("half_oct1_btn3", 851);

    keys_in = '0; latch_in = 1'b1;
    wait_cycles(LAT + 2);
    keys_in = 12'h008; wait_cycles(LAT + 2); keys_in = '0; wait_cycles(LAT + 2);
    check("latch_set", 32'(pads.Dout), 32'd4);
    keys_in = 12'h008; wait_cycles(LAT + 2); keys_in = '0; wait_cycles(LAT + 2);
    check("latch_clear", 32'(pads.Dout), 32'hF);
    keys_in = 12'h100; wait_cycles(LAT + 2); keys_in = '0; wait_cycles(LAT + 2);
    keys_in = 12'h200; wait_cycles(LAT + 2); keys_in = '0; wait_cycles(LAT + 2);
    check("latch_btn0", 32'(pads.Dout), 32'd0);
    check("latch_row4", 32'(rgb_obs), 32'h400);

    latch_in = 1'b0; keys_in = 12'h800; oct_in = 3'd7; mute_in = 1'b1;
    wait_cycles(LAT + 20);
    check("mute_dout", 32'(pads.Dout), 32'd11);
    check("mute_pout", 32'(pads.Pout), 32'd0);
    mute_in = 1'b0;
    wait_cycles(3);
    measure_half("half_oct7_sharp", 7);
    oct_in = 3'd6;
    wait_cycles(3);
    measure_half("half_oct6_sharp", 15);

    keys_in = 12'h001; wait_cycles(40);
    RST = 1'b0; wait_cycles(1);
    check("midtone_rst_pout", 32'(pads.Pout), 32'd0);
    RST = 1'b1; wait_cycles(LAT + 40);

    keys_in = '0; oct_in = 3'd0;
    wait_cycles(LAT + 3);
`ifdef LAUNCHPAD_DEBOUNCE_EN
    keys_in = 12'h002; wait_cycles(2); keys_in = '0;
    for (int i = 0; i < 12; i++) begin
      wait_cycles(1);
      check("glitch_dout", 32'(pads.Dout), 32'hF);
    end
`endif
    keys_in = 12'h002;
    seen = 0;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      @(negedge CLK);
      if (pads.Dout == 4'd2) seen = i;
    end
    check("press_latency", 32'(seen), 32'(LAT));

    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 19) == 0) begin
        for (int b = 0; b < 12; b++) keys_in[b] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 149) == 0) oct_in = 3'($urandom_range(3, 7));
      if ($urandom_range(0, 299) == 0) mute_in = ~mute_in;
      if ($urandom_range(0, 249) == 0) latch_in = ~latch_in;
      if ($urandom_range(0, 99) == 0)  col_in = 2'($urandom_range(0, 3));
      RST = ($urandom_range(0, 499) != 0);
    end
    RST = 1'b1;
    wait_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
